// File: rtl/ps2_pkg.sv
// Shared constants, key codes and frame FSM encoding for the PS/2 keyboard receiver.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BREAK = 8'hF0;

  localparam logic [7:0] KEY_A     = 8'h1C;
  localparam logic [7:0] KEY_D     = 8'h23;
  localparam logic [7:0] KEY_W     = 8'h1D;
  localparam logic [7:0] KEY_S     = 8'h1B;
  localparam logic [7:0] KEY_SPACE = 8'h29;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  // True when the eight data bits plus the parity bit hold an odd number of ones.
  function automatic logic odd_parity(input logic [7:0] data_bits, input logic parity_bit);
    return ^{data_bits, parity_bit};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer followed by an optional run-length glitch filter for one PS/2 line.
module ps2_line_filter #(
  parameter int unsigned FILTER_LEN = 8,
  parameter bit          BYPASS     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic line_in,
  output logic line_out
);

  logic meta;
  logic sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      sync <= 1'b1;
    end else begin
      meta <= line_in;
      sync <= meta;
    end
  end

  generate
    if (BYPASS) begin : g_bypass
      assign line_out = sync;
    end else begin : g_filter
      localparam int unsigned CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

      logic [CNT_W-1:0] run_cnt;
      logic             level;

      // run_cnt counts consecutive samples that disagree with the accepted level;
      // the FILTER_LEN-th such sample flips the level.
      always_ff @(posedge clk) begin
        if (rst) begin
          level   <= 1'b1;
          run_cnt <= '0;
        end else if (sync == level) begin
          run_cnt <= '0;
        end else if (run_cnt == CNT_W'(FILTER_LEN - 1)) begin
          level   <= sync;
          run_cnt <= '0;
        end else begin
          run_cnt <= run_cnt + 1'b1;
        end
      end

      assign line_out = level;
    end
  endgenerate

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: frames bytes, strips E0/F0 prefixes and delivers make codes with a ready pulse.
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned READY_CYCLES   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keyboard_data,
  output logic       keyboard_ready,
  output logic       keyboard_ext,
  output logic       frame_err
);

  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned RDY_W = (READY_CYCLES > 1) ? $clog2(READY_CYCLES + 1) : 1;

  logic clk_filt;
  logic clk_prev;
  logic data_sync;
  logic strobe;

  ps2_state_t       state;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift_reg;
  logic             parity_ok;
  logic             ext_pending;
  logic             break_pending;
  logic [TO_W-1:0]  timeout_cnt;
  logic [RDY_W-1:0] ready_cnt;

  ps2_line_filter #(
    .FILTER_LEN(FILTER_LEN),
    .BYPASS    (1'b0)
  ) u_clk_filter (
    .clk     (clk),
    .rst     (rst),
    .line_in (ps2_clk),
    .line_out(clk_filt)
  );

  // Data is only sampled mid-bit on a clock strobe, so it needs synchronizing but not filtering.
  ps2_line_filter #(
    .FILTER_LEN(FILTER_LEN),
    .BYPASS    (1'b1)
  ) u_data_filter (
    .clk     (clk),
    .rst     (rst),
    .line_in (ps2_data),
    .line_out(data_sync)
  );

  assign strobe = clk_prev & ~clk_filt;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_prev       <= 1'b1;
      state          <= IDLE;
      bit_cnt        <= '0;
      shift_reg      <= '0;
      parity_ok      <= 1'b0;
      ext_pending    <= 1'b0;
      break_pending  <= 1'b0;
      timeout_cnt    <= '0;
      ready_cnt      <= '0;
      keyboard_data  <= '0;
      keyboard_ready <= 1'b0;
      keyboard_ext   <= 1'b0;
      frame_err      <= 1'b0;
    end else begin
      clk_prev  <= clk_filt;
      frame_err <= 1'b0;

      if (keyboard_ready) begin
        if (ready_cnt == '0) begin
          keyboard_ready <= 1'b0;
        end else begin
          ready_cnt <= ready_cnt - 1'b1;
        end
      end

      if (state == IDLE || strobe) begin
        timeout_cnt <= '0;
      end else if (timeout_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
        state       <= IDLE;
        bit_cnt     <= '0;
        shift_reg   <= '0;
        timeout_cnt <= '0;
        frame_err   <= 1'b1;
      end else begin
        timeout_cnt <= timeout_cnt + 1'b1;
      end

      if (strobe) begin
        unique case (state)
          IDLE: begin
            if (!data_sync) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            shift_reg <= {data_sync, shift_reg[7:1]};
            if (bit_cnt == 3'd7) begin
              state <= PARITY;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          PARITY: begin
            parity_ok <= odd_parity(shift_reg, data_sync);
            state     <= STOP;
          end
          STOP: begin
            state   <= IDLE;
            bit_cnt <= '0;
            if (data_sync && parity_ok) begin
              if (shift_reg == PS2_EXT) begin
                ext_pending <= 1'b1;
              end else if (shift_reg == PS2_BREAK) begin
                break_pending <= 1'b1;
              end else if (break_pending) begin
                break_pending <= 1'b0;
                ext_pending   <= 1'b0;
              end else begin
                // Overrides the countdown above, so a back-to-back delivery restarts the pulse.
                keyboard_data  <= shift_reg;
                keyboard_ext   <= ext_pending;
                ext_pending    <= 1'b0;
                keyboard_ready <= 1'b1;
                ready_cnt      <= RDY_W'(READY_CYCLES - 1);
              end
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx: stimulus queues expected deliveries/errors, a monitor checks them.
module tb_ps2_keyboard_rx;

  localparam int unsigned FILTER_LEN     = 8;
  localparam int unsigned TIMEOUT_CYCLES = 2000;
  localparam int unsigned READY_CYCLES   = 4;
  localparam int unsigned HALF           = 30;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] keyboard_data;
  logic       keyboard_ready;
  logic       keyboard_ext;
  logic       frame_err;

  ps2_keyboard_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .READY_CYCLES  (READY_CYCLES)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ps2_clk       (ps2_clk),
    .ps2_data      (ps2_data),
    .keyboard_data (keyboard_data),
    .keyboard_ready(keyboard_ready),
    .keyboard_ext  (keyboard_ext),
    .frame_err     (frame_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    logic       ext;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          err_expected = 0;
  int          err_seen = 0;
  int unsigned last_err_cyc = 0;
  int unsigned last_fall_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_code(input logic [7:0] data, input logic ext);
    exp_t e;
    e.data = data;
    e.ext  = ext;
    exp_q.push_back(e);
  endtask

  // Sends the first nbits bits of an 11-bit frame (start, 8 data LSB first, odd parity, stop).
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits, input bit glitch);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      if (glitch) begin
        wait_cyc(8);
        ps2_clk = 1'b0;
        wait_cyc(3);
        ps2_clk = 1'b1;
        wait_cyc(HALF - 11);
      end else begin
        wait_cyc(HALF);
      end
      ps2_clk = 1'b0;
      last_fall_cyc = cyc;
      wait_cyc(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    wait_cyc(HALF + 20);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b0, 11, 1'b0);
  endtask

  // Monitor / scoreboard
  exp_t        mon_e;
  logic        rdy_prev = 1'b0;
  logic        err_prev = 1'b0;
  int unsigned rdy_len = 0;

  always @(negedge clk) begin
    if (rst) begin
      rdy_prev = 1'b0;
      err_prev = 1'b0;
      rdy_len  = 0;
    end else begin
      if (keyboard_ready && !rdy_prev) begin
        check("delivery_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("deliver_data", keyboard_data, mon_e.data);
          check("deliver_ext", keyboard_ext, mon_e.ext);
        end
        rdy_len = 1;
      end else if (keyboard_ready) begin
        rdy_len++;
      end else if (rdy_prev) begin
        check("ready_width", rdy_len, READY_CYCLES);
      end
      if (frame_err) begin
        if (err_prev) begin
          check("frame_err_single_cycle", 1'b0, 1'b1);
        end else begin
          check("frame_err_expected", err_expected > 0, 1);
          if (err_expected > 0) err_expected--;
          err_seen++;
          last_err_cyc = cyc;
        end
      end
      rdy_prev = keyboard_ready;
      err_prev = frame_err;
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          base;
    int unsigned w;
    int unsigned lat;

    wait_cyc(5);
    check("reset_data", keyboard_data, 8'h00);
    check("reset_ready", keyboard_ready, 1'b0);
    check("reset_ext", keyboard_ext, 1'b0);
    check("reset_err", frame_err, 1'b0);
    rst = 1'b0;
    wait_cyc(20);

    expect_code(8'h1C, 1'b0);
    send_byte(8'h1C);

    send_byte(8'hF0);
    send_byte(8'h1C);
    check("release_hold_data", keyboard_data, 8'h1C);

    send_byte(8'hE0);
    expect_code(8'h75, 1'b1);
    send_byte(8'h75);
    check("ext_held_after_ready", keyboard_ext, 1'b1);
    expect_code(8'h23, 1'b0);
    send_byte(8'h23);

    err_expected++;
    send_frame(8'h23, 1'b1, 11, 1'b0);
    check("bad_parity_hold_data", keyboard_data, 8'h23);
    expect_code(8'h1D, 1'b0);
    send_byte(8'h1D);
    expect_code(8'h1D, 1'b0);
    send_byte(8'h1D);

    // Timeout: start bit plus four data bits, then silence.
    err_expected++;
    base = err_seen;
    send_frame(8'h29, 1'b0, 5, 1'b0);
    w = 0;
    while (err_seen == base && w < TIMEOUT_CYCLES + 200) begin
      wait_cyc(1);
      w++;
    end
    check("timeout_fired", err_seen - base, 1);
    lat = last_err_cyc - last_fall_cyc;
    check("timeout_latency", lat >= TIMEOUT_CYCLES && lat <= TIMEOUT_CYCLES + FILTER_LEN + 8, 1);
    wait_cyc(20);
    expect_code(8'h29, 1'b0);
    send_byte(8'h29);

    // Short low glitches with data low would start a frame if they got through.
    ps2_data = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ps2_clk = 1'b0;
      wait_cyc(3);
      ps2_clk = 1'b1;
      wait_cyc(12);
    end
    ps2_data = 1'b1;
    wait_cyc(20);
    expect_code(8'h1C, 1'b0);
    send_frame(8'h1C, 1'b0, 11, 1'b1);

    // Extended release: E0 F0 75 delivers nothing and clears the extension flag.
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    expect_code(8'h23, 1'b0);
    send_byte(8'h23);

    send_frame(8'h55, 1'b0, 4, 1'b0);
    rst = 1'b1;
    wait_cyc(3);
    check("midrst_data", keyboard_data, 8'h00);
    check("midrst_ready", keyboard_ready, 1'b0);
    check("midrst_ext", keyboard_ext, 1'b0);
    check("midrst_err", frame_err, 1'b0);
    rst = 1'b0;
    wait_cyc(10);
    expect_code(8'h1B, 1'b0);
    send_byte(8'h1B);

    wait_cyc(50);
    check("pending_deliveries", exp_q.size(), 0);
    check("pending_errors", err_expected, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
